// File: rtl/fetch_ctrl_pkg.sv
// Shared constants and state encoding for the instruction-fetch sequencer.
package fetch_ctrl_pkg;

  localparam logic        RST_ACTIVE = 1'b0;
  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned INST_W_DEF = 32;
  localparam logic [31:0] ZERO_ADDR  = 32'h0000_0000;
  localparam int unsigned PC_INC     = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_WAIT    = 2'd2,
    ST_DISCARD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_buf.sv
// One-entry holding register for a fetched instruction and its PC.
module fetch_buf
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned INST_W = INST_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              load,
  input  logic              consume,
  input  logic [INST_W-1:0] load_inst,
  input  logic [ADDR_W-1:0] load_pc,
  output logic              valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] pc
);

  // Flush beats reload, reload beats a same-cycle consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      inst  <= '0;
      pc    <= '0;
    end else begin
      if (flush) begin
        valid <= 1'b0;
      end else if (load) begin
        valid <= 1'b1;
        inst  <= load_inst;
        pc    <= load_pc;
      end else if (consume) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs the imem handshake, drops stale responses.
// Optional FETCH_MISALIGN_CHK_EN: reject misaligned redirects and raise a sticky flag.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter int unsigned       INST_W   = INST_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(ZERO_ADDR)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              stall_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [INST_W-1:0] imem_rdata_i,
  output logic              inst_valid_o,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              fetch_misalign_o
);

  fetch_state_e      state;
  fetch_state_e      state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] req_pc;
  logic [ADDR_W-1:0] redir_tgt;
  logic              redir_ok;
  logic              buf_free;
  logic              fire;
  logic              buf_load;
  logic              buf_flush;
  logic              buf_consume;

  // Redirect qualification; redirects are ignored while still in IDLE.
`ifdef FETCH_MISALIGN_CHK_EN
  logic misalign_hit;
  logic misalign;

  always_comb begin
    redir_tgt    = redirect_pc_i;
    redir_ok     = redirect_valid_i && (state != ST_IDLE) && (redirect_pc_i[1:0] == 2'b00);
    misalign_hit = redirect_valid_i && (state != ST_IDLE) && (redirect_pc_i[1:0] != 2'b00);
  end

  // Sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign <= 1'b0;
    end else if (misalign_hit) begin
      misalign <= 1'b1;
    end
  end

  assign fetch_misalign_o = misalign;
`else
  always_comb begin
    redir_tgt = redirect_pc_i & {{(ADDR_W-2){1'b1}}, 2'b00};
    redir_ok  = redirect_valid_i && (state != ST_IDLE);
  end

  assign fetch_misalign_o = 1'b0;
`endif

  // Next-state, request and buffer-control decode.
  always_comb begin
    buf_free   = !inst_valid_o || !stall_i;
    imem_req_o = 1'b0;
    state_nxt  = state;
    case (state)
      ST_IDLE: begin
        state_nxt = ST_REQ;
      end
      ST_REQ: begin
        imem_req_o = buf_free;
        if (redir_ok) begin
          state_nxt = (buf_free && imem_gnt_i) ? ST_DISCARD : ST_REQ;
        end else if (buf_free && imem_gnt_i) begin
          state_nxt = ST_WAIT;
        end else begin
          state_nxt = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid_i) begin
          state_nxt = ST_REQ;
        end else if (redir_ok) begin
          state_nxt = ST_DISCARD;
        end else begin
          state_nxt = ST_WAIT;
        end
      end
      ST_DISCARD: begin
        state_nxt = imem_rvalid_i ? ST_REQ : ST_DISCARD;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    fire        = imem_req_o && imem_gnt_i;
    buf_load    = (state == ST_WAIT) && imem_rvalid_i && !redir_ok;
    buf_flush   = redir_ok;
    buf_consume = inst_valid_o && !stall_i;

    if (redir_ok) begin
      pc_nxt = redir_tgt;
    end else if (fire) begin
      pc_nxt = pc + ADDR_W'(PC_INC);
    end else begin
      pc_nxt = pc;
    end
  end

  // FSM state, PC and address of the request in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (fire) begin
        req_pc <= pc;
      end
    end
  end

  assign pc_o        = pc;
  assign imem_addr_o = pc;

  fetch_buf #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W)
  ) u_fetch_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (buf_flush),
    .load      (buf_load),
    .consume   (buf_consume),
    .load_inst (imem_rdata_i),
    .load_pc   (req_pc),
    .valid     (inst_valid_o),
    .inst      (inst_o),
    .pc        (inst_pc_o)
  );

endmodule
